modulo_condicionador_botoes: RTL

MODULO_CONDICIONADOR_BOTOES -- requirements
Module: modulo_condicionador_botoes

---
 rtl/modulo_condicionador_botoes.sv | 139 +++++++++++++
 1 files changed

// File: rtl/modulo_condicionador_botoes.sv
// Button conditioner: per-button sync + debounce, press strobes, and
// auto-repeat on the count button (IDLE -> DELAY -> REPEAT).

module cb_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    sync;
  logic [DW-1:0] cnt;
  logic          pressed;
  logic          hit;

  // Raw buttons are active-low; synchronizer idles at 1 (released).
  assign pressed = ~sync[1];
  assign hit     = (pressed != level) && (cnt == DW'(DEBOUNCE_CYCLES));
  assign rise    = hit & pressed;
  assign fall    = hit & ~pressed;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (pressed == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= pressed;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module modulo_condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_confirm_raw,
  input  logic btn_count_raw,
  output logic confirm_clean,
  output logic count_clean,
  output logic confirm_pulse,
  output logic count_pulse,
  output logic repeat_active
);
  localparam int NUM_BTN = 2;
  localparam int RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [NUM_BTN-1:0] raw, level, rise, fall;
  state_t             state, state_n;
  logic [RW-1:0]      rcnt, rcnt_n;
  logic               rpt;

  // Lane 0 = confirm, lane 1 = count.
  assign raw = {btn_count_raw, btn_confirm_raw};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    cb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .clr   (clr),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign confirm_clean = level[0];
  assign count_clean   = level[1];
  assign repeat_active = (state == REPEAT);

  // A release acceptance wins over a due repeat so no pulse leaks on that edge.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    rpt     = 1'b0;
    case (state)
      IDLE: if (rise[1]) begin
        state_n = DELAY;
        rcnt_n  = '0;
      end
      DELAY: if (fall[1]) begin
        state_n = IDLE;
        rcnt_n  = '0;
      end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
        rpt     = 1'b1;
        state_n = REPEAT;
        rcnt_n  = '0;
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
      REPEAT: if (fall[1]) begin
        state_n = IDLE;
        rcnt_n  = '0;
      end else if (rcnt == RW'(REPEAT_RATE - 1)) begin
        rpt    = 1'b1;
        rcnt_n = '0;
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
      default: begin
        state_n = IDLE;
        rcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      rcnt          <= '0;
      confirm_pulse <= 1'b0;
      count_pulse   <= 1'b0;
    end else begin
      state         <= state_n;
      rcnt          <= rcnt_n;
      confirm_pulse <= rise[0];
      count_pulse   <= rise[1] | rpt;
    end
  end
endmodule
